// File: rtl/inject_sched.sv
// Round-robin injection scheduler: grants N one-shot buffers in quantum slices,
// gated by downstream link credits, and registers the granted buffer's flit.
module inject_sched #(
    parameter int N         = 16,
    parameter int BUF_DEPTH = 30,
    parameter int QUANTUM   = 4,
    parameter int CREDITS   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N-1:0]    buf_en,
    input  logic [N-1:0]    buf_valid,
    input  logic [20*N-1:0] buf_data,
    input  logic            credit_ret,
    output logic [19:0]     out_data,
    output logic            out_valid,
    output logic            busy,
    output logic            all_done,
    output logic            err
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int QW = $clog2(QUANTUM + 1);
    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [4:0]    DEPTH5 = 5'(BUF_DEPTH);
    localparam logic [QW-1:0] QMAX   = QW'(QUANTUM);
    localparam logic [CW-1:0] CMAX   = CW'(CREDITS);
    localparam logic [N-1:0]  ONE_N  = N'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_g;
    logic [GW-1:0] w_g_nxt;
    logic [GW-1:0] w_g_sel;
    logic [QW-1:0] r_qcnt;
    logic [QW-1:0] w_qcnt_nxt;
    logic [CW-1:0] r_credits;
    logic [CW-1:0] w_credits_nxt;
    logic [4:0]    r_issued [N];
    logic [N-1:0]  r_primed;
    logic [N-1:0]  r_prev_iss;
    logic [19:0]   r_out_data;
    logic          r_out_valid;
    logic          r_all_done;
    logic          r_err;

    logic          w_issue;
    logic          w_prime;
    logic          w_cur_fin;
    logic          w_rot;
    logic          w_any_left;
    logic          w_multi;
    logic          w_spur;
    logic          w_one;
    logic          w_cred_ovf;
    logic [19:0]   w_sel_data;

    assign w_prime = (r_state == S_PRIME);
    assign w_issue = (r_state == S_STREAM) && (r_credits != '0)
                     && (r_issued[r_g] < DEPTH5) && (r_qcnt < QMAX);

    // Finished-ness of the current grant as it will be after this cycle.
    assign w_cur_fin = w_issue ? ((r_issued[r_g] + 5'd1) >= DEPTH5)
                               : (r_issued[r_g] >= DEPTH5);

    assign w_rot = (r_state == S_STREAM) &&
                   (w_issue ? (((r_qcnt + QW'(1)) >= QMAX) || w_cur_fin)
                            : ((r_qcnt >= QMAX) || w_cur_fin));

    // Walk backwards so the nearest unfinished index after g wins.
    always_comb begin : grant_search
        int            idx;
        logic [GW-1:0] cand;
        logic          unf;
        w_any_left = 1'b0;
        w_g_sel    = r_g;
        idx        = 0;
        cand       = '0;
        unf        = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx  = (int'(r_g) + k) % N;
            cand = GW'(idx);
            unf  = (cand == r_g) ? !w_cur_fin : (r_issued[cand] < DEPTH5);
            if (unf) begin
                w_any_left = 1'b1;
                w_g_sel    = cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_qcnt_nxt  = r_qcnt;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_g_nxt     = '0;
                    w_qcnt_nxt  = '0;
                    w_state_nxt = r_primed[0] ? S_STREAM : S_PRIME;
                end
            end
            S_PRIME: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_issue) begin
                    w_qcnt_nxt = r_qcnt + QW'(1);
                end
                if (w_rot) begin
                    w_qcnt_nxt = '0;
                    if (!w_any_left) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_g_nxt     = w_g_sel;
                        w_state_nxt = r_primed[w_g_sel] ? S_STREAM : S_PRIME;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        buf_en = '0;
        if (w_issue || w_prime) begin
            buf_en[r_g] = 1'b1;
        end
    end

    // Simultaneous issue and return cancel; a return at full is dropped.
    always_comb begin
        w_credits_nxt = r_credits;
        w_cred_ovf    = 1'b0;
        unique case ({w_issue, credit_ret})
            2'b10: w_credits_nxt = r_credits - CW'(1);
            2'b01: begin
                if (r_credits == CMAX) begin
                    w_cred_ovf = 1'b1;
                end else begin
                    w_credits_nxt = r_credits + CW'(1);
                end
            end
            default: w_credits_nxt = r_credits;
        endcase
    end

    assign w_multi = (buf_valid & (buf_valid - ONE_N)) != '0;
    assign w_one   = (buf_valid != '0) && !w_multi;
    assign w_spur  = |(buf_valid & ~r_prev_iss);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (buf_valid[i]) begin
                w_sel_data = buf_data[20*i +: 20];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_g         <= '0;
            r_qcnt      <= '0;
            r_credits   <= CMAX;
            r_primed    <= '0;
            r_prev_iss  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_all_done  <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_issued[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_g        <= w_g_nxt;
            r_qcnt     <= w_qcnt_nxt;
            r_credits  <= w_credits_nxt;
            r_prev_iss <= w_issue ? buf_en : '0;
            if (w_issue) begin
                r_issued[r_g] <= r_issued[r_g] + 5'd1;
            end
            if (w_prime) begin
                r_primed[r_g] <= 1'b1;
            end
            r_out_valid <= w_one;
            if (w_one) begin
                r_out_data <= w_sel_data;
            end
            if (w_state_nxt == S_DONE && w_credits_nxt == CMAX) begin
                r_all_done <= 1'b1;
            end
            if (w_multi || w_spur || w_cred_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign all_done  = r_all_done;
    assign err       = r_err;
    assign busy      = (r_state == S_PRIME) || (r_state == S_STREAM);

endmodule

// File: tb/tb_inject_sched.sv
// Self-checking bench for inject_sched: buffer models, credit loopback
// and a flit scoreboard built from an independent round-robin schedule.
module tb_inject_sched;

    localparam int N = 16;
    localparam int D = 30;
    localparam int Q = 4;
    localparam int C = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [N-1:0]    buf_en;
    logic [N-1:0]    buf_valid;
    logic [20*N-1:0] buf_data;
    logic            credit_ret;
    logic [19:0]     out_data;
    logic            out_valid;
    logic            busy;
    logic            all_done;
    logic            err;

    int tests = 0;
    int fails = 0;

    logic [19:0] sbq [$];
    logic        auto_ret = 1'b0;
    logic        man_ret = 1'b0;
    logic [N-1:0] force_vec = '0;

    logic [N-1:0] m_valid;
    logic [N-1:0] m_primed;
    logic [19:0]  m_data [N];
    int           m_cnt [N];
    logic         ret_d1;
    logic         ret_d2;

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [19:0] word(input int b, input int k);
        return {4'(b), 8'(k), 8'h5A};
    endfunction

    // Buffer model: first enable primes, later enables emit the next word.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid  <= '0;
            m_primed <= '0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  <= 0;
                m_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] <= 1'b0;
                if (buf_en[i]) begin
                    if (!m_primed[i]) begin
                        m_primed[i] <= 1'b1;
                    end else begin
                        m_valid[i] <= 1'b1;
                        m_data[i]  <= word(i, m_cnt[i]);
                        m_cnt[i]   <= m_cnt[i] + 1;
                    end
                end
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_d1 <= 1'b0;
            ret_d2 <= 1'b0;
        end else begin
            ret_d1 <= out_valid & auto_ret;
            ret_d2 <= ret_d1;
        end
    end

    assign buf_valid  = m_valid | force_vec;
    assign credit_ret = auto_ret ? ret_d2 : man_ret;

    for (genvar gi = 0; gi < N; gi++) begin : g_data
        assign buf_data[20*gi +: 20] = m_data[gi];
    end

    inject_sched #(
        .N(N), .BUF_DEPTH(D), .QUANTUM(Q), .CREDITS(C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .buf_en    (buf_en),
        .buf_valid (buf_valid),
        .buf_data  (buf_data),
        .credit_ret(credit_ret),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .all_done  (all_done),
        .err       (err)
    );

    task automatic do_reset();
        rst       = 1'b0;
        start     = 1'b0;
        auto_ret  = 1'b0;
        man_ret   = 1'b0;
        force_vec = '0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        tests++;
        if (buf_en !== '0 || out_valid !== 1'b0 || out_data !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: buf_en=%h out_valid=%b out_data=%h required 0/0/0",
                     buf_en, out_valid, out_data);
        end
        tests++;
        if (busy !== 1'b0 || all_done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: busy=%b all_done=%b err=%b required 0/0/0",
                     busy, all_done, err);
        end
        do_reset();
        tests++;
        if (busy !== 1'b0 || buf_en !== '0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b buf_en=%h required 0/0", busy, buf_en);
        end
    endtask

    task automatic test_full_run();
        int rem [N];
        int left;
        int take;
        int budget;
        int seen;
        int cyc;
        int first_cyc;
        int fourth_cyc;
        int extra;
        logic [19:0] exp;
        logic flag;
        do_reset();
        for (int b = 0; b < N; b++) rem[b] = D;
        left = N * D;
        while (left > 0) begin
            for (int b = 0; b < N; b++) begin
                take = (rem[b] < Q) ? rem[b] : Q;
                for (int j = 0; j < take; j++) sbq.push_back(word(b, D - rem[b] + j));
                rem[b] -= take;
                left   -= take;
            end
        end
        auto_ret = 1'b1;
        pulse_start();
        budget     = 4000;
        seen       = 0;
        cyc        = 0;
        first_cyc  = -1;
        fourth_cyc = -1;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            cyc++;
            if (out_valid) begin
                if (seen == 0) first_cyc = cyc;
                if (seen == 3) fourth_cyc = cyc;
                exp = sbq.pop_front();
                tests++;
                if (out_data !== exp) begin
                    fails++;
                    $display("FAIL flit_order #%0d: got %h required %h", seen, out_data, exp);
                end
                seen++;
            end
        end
        tests++;
        if (budget == 0) begin
            fails++;
            $display("FAIL run_timeout: %0d flits seen, required %0d", seen, N * D);
        end
        tests++;
        if (first_cyc != 3) begin
            fails++;
            $display("FAIL prime_latency: first flit at cycle %0d required 3", first_cyc);
        end
        tests++;
        if (fourth_cyc != 6) begin
            fails++;
            $display("FAIL back_to_back: fourth flit at cycle %0d required 6", fourth_cyc);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL extra_flits: got %0d required 0", extra);
        end
        tests++;
        if (all_done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL done_flags: all_done=%b busy=%b err=%b required 1/0/0",
                     all_done, busy, err);
        end
        pulse_start();
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || buf_en != '0 || !all_done) flag = 1'b1;
        end
        tests++;
        if (flag !== 1'b0) begin
            fails++;
            $display("FAIL restart_after_done: activity=%b required 0", flag);
        end
    endtask

    task automatic test_credit_stall();
        int cnt;
        logic [19:0] exp;
        logic en_seen;
        do_reset();
        for (int k = 0; k < 4; k++) sbq.push_back(word(0, k));
        pulse_start();
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                exp = (sbq.size() > 0) ? sbq.pop_front() : 20'hFFFFF;
                tests++;
                if (out_data !== exp) begin
                    fails++;
                    $display("FAIL stall_data: got %h required %h", out_data, exp);
                end
            end
        end
        tests++;
        if (cnt != 4) begin
            fails++;
            $display("FAIL stall_count: got %0d flits required 4", cnt);
        end
        en_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (buf_en != '0) en_seen = 1'b1;
        end
        tests++;
        if (en_seen !== 1'b0) begin
            fails++;
            $display("FAIL stall_enable: buf_en activity=%b required 0", en_seen);
        end
        sbq.push_back(word(1, 0));
        man_ret = 1'b1;
        @(negedge clk);
        man_ret = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                exp = (sbq.size() > 0) ? sbq.pop_front() : 20'hFFFFF;
                tests++;
                if (out_data !== exp) begin
                    fails++;
                    $display("FAIL one_credit_data: got %h required %h", out_data, exp);
                end
            end
        end
        tests++;
        if (cnt != 1) begin
            fails++;
            $display("FAIL one_credit_count: got %0d flits required 1", cnt);
        end
        sbq.push_back(word(1, 1));
        sbq.push_back(word(1, 2));
        man_ret = 1'b1;
        repeat (2) @(negedge clk);
        man_ret = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                exp = (sbq.size() > 0) ? sbq.pop_front() : 20'hFFFFF;
                tests++;
                if (out_data !== exp) begin
                    fails++;
                    $display("FAIL same_cycle_data: got %h required %h", out_data, exp);
                end
            end
        end
        tests++;
        if (cnt != 2 || err !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle_credit: got %0d flits err=%b required 2 flits err=0",
                     cnt, err);
        end
    endtask

    task automatic test_credit_overflow();
        do_reset();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: got %b required 0", err);
        end
        man_ret = 1'b1;
        @(negedge clk);
        man_ret = 1'b0;
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL credit_overflow: err=%b required 1", err);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: err=%b required 1", err);
        end
    endtask

    task automatic test_multi_valid();
        do_reset();
        force_vec = N'(1) << 3 | N'(1) << 5;
        @(negedge clk);
        force_vec = '0;
        tests++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL multi_valid: err=%b out_valid=%b required 1/0", err, out_valid);
        end
        do_reset();
        force_vec = N'(1) << 7;
        @(negedge clk);
        force_vec = '0;
        tests++;
        if (err !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL spurious_valid: err=%b out_valid=%b required 1/1", err, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        int cnt;
        int cyc;
        int first_cyc;
        logic [19:0] exp;
        do_reset();
        auto_ret = 1'b1;
        pulse_start();
        budget = 300;
        while (buf_en[2] !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        tests++;
        if (budget == 0) begin
            fails++;
            $display("FAIL reach_buf2: buf_en=%h required bit 2 set", buf_en);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (buf_en !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 20'h0) begin
            fails++;
            $display("FAIL async_reset: buf_en=%h out_valid=%b busy=%b out_data=%h required 0",
                     buf_en, out_valid, busy, out_data);
        end
        auto_ret = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) sbq.push_back(word(0, k));
        pulse_start();
        cnt       = 0;
        cyc       = 0;
        first_cyc = -1;
        repeat (40) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (cnt == 0) first_cyc = cyc;
                cnt++;
                exp = (sbq.size() > 0) ? sbq.pop_front() : 20'hFFFFF;
                tests++;
                if (out_data !== exp) begin
                    fails++;
                    $display("FAIL restart_data: got %h required %h", out_data, exp);
                end
            end
        end
        tests++;
        if (cnt != 4 || first_cyc != 3) begin
            fails++;
            $display("FAIL restart_prime: %0d flits first at %0d required 4 flits first at 3",
                     cnt, first_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_credit_stall();
        test_credit_overflow();
        test_multi_valid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inject_sched.md
INJECT_SCHED -- requirements
Module: inject_sched

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- N, 16, number of attached injection buffers
- BUF_DEPTH, 30, words each buffer emits before going permanently idle
- QUANTUM, 4, max words issued per grant before rotating
- CREDITS, 4, downstream link credits
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- rst, in, 1, reset, asynchronous, active-low
- start, in, 1, one-cycle pulse, begins a schedule run
- buf_en, out, N, per-buffer enable, at most one bit set
- buf_valid, in, N, per-buffer out_valid
- buf_data, in, 20*N, buffer i word on bits [20i+19:20i]
- credit_ret, in, 1, one credit returned this cycle
- out_data, out, 20, registered injected flit
- out_valid, out, 1, out_data valid this cycle
- busy, out, 1, high in PRIME/STREAM
- all_done, out, 1, sticky, all buffers drained
- err, out, 1, sticky protocol error

Function
REQ-003 FSM states: IDLE, PRIME, STREAM, DONE.
REQ-004 IDLE: start=1 -> grant g=0 -> PRIME if buffer 0 unprimed, else STREAM; start ignored outside IDLE.
REQ-005 PRIME: buf_en[g]=1 for exactly one cycle; set primed[g]; no credit consumed, no issue counted; next state STREAM.
REQ-006 STREAM issue condition: credits>0 and issued[g]<BUF_DEPTH and qcnt<QUANTUM; when true, buf_en[g]=1, credits-1, issued[g]+1, qcnt+1; else buf_en=0.
REQ-007 Rotation: when qcnt reaches QUANTUM or issued[g] reaches BUF_DEPTH, on the next cycle g = first index after g (cyclic, mod N) with issued<BUF_DEPTH; qcnt cleared; state PRIME if that buffer unprimed, else STREAM.
REQ-008 If no unfinished buffer remains, state DONE; all_done=1 once credits are back at CREDITS or on entry if already so; all_done remains 1 until reset.
REQ-009 Output capture: if exactly one buf_valid bit i is set, out_data<=buf_data[i], out_valid<=1 next cycle; otherwise out_valid<=0, out_data holds.
REQ-010 Latency: buf_en issue in cycle t -> buffer valid in t+1 -> out_valid in t+2; back-to-back issues give one flit per cycle.
REQ-011 Credit counter: range 0..CREDITS; issue-only -1, credit_ret-only +1, both in same cycle unchanged; credit_ret at CREDITS ignored and sets err.
REQ-012 Credit exhaustion: credits=0 stalls issue (buf_en=0), grant and qcnt held; resumes the cycle after credit_ret.
REQ-013 err sets on: more than one buf_valid bit high; buf_valid[i] high without buf_en[i] issue in previous cycle; credit overflow per REQ-011.
REQ-014 busy=1 in PRIME and STREAM only.
REQ-015 Per-buffer counters issued[i] are 5-bit; primed[i], issued[i] persist across runs (buffers are one-shot); a second start after DONE is ignored.

Reset
REQ-016 rst low, any time including mid-burst: state IDLE, buf_en=0, out_valid=0, out_data=0, credits=CREDITS, g=0, qcnt=0, all issued=0, all primed=0, all_done=0, err=0; takes effect without clock.
REQ-017 Outputs registered; buf_en driven from registered state, no combinational path from buf_valid to buf_en.

Verification
REQ-018 Scenario 1: start, 16 buffer models, credit_ret 2 cycles after each out_valid -> 480 flits, each buffer's 30 words in order, grants rotate 0..15 in 4-word slices, then all_done=1.
REQ-019 Scenario 2: credit_ret held 0 -> exactly 4 flits then buf_en=0 indefinitely; one credit_ret pulse -> exactly one more flit.
REQ-020 Scenario 3: credit_ret and issue in same cycle with credits=1 -> credits stay 1; credit_ret at credits=4 -> err=1.
REQ-021 Scenario 4: force buf_valid[3] and [5] high together -> err=1, out_valid=0 that cycle.
REQ-022 Scenario 5: rst low during buffer 2's quantum -> next cycle buf_en=0, out_valid=0, credits=4; after release start restarts at buffer 0 with PRIME.
REQ-023 Scenario 6: QUANTUM=4, BUF_DEPTH=30 -> buffer's 8th grant issues 2 words then rotates; finished buffers skipped on subsequent passes.
